sd_response_receiver: RTL and testbench
=======================================

Name: sd_response_receiver

Overview:
- Parametrised SPI-mode SD card response receiver: waits for the response start bit on DO, shifts in a run-time selectable number of bits (R1 = 8, R3/R7 = 40), then reports completion or an NCR timeout.
- Sits between the SD command sender and the init/read/write controllers.
- Generalises the fixed 8-bit R1 receiver: variable length, captured data, timeout and a busy flag.

Parameters:
- MAX_BITS, 40, longest response in bits; also RESPONSE width.
- TIMEOUT_CYCLES, 80, consecutive DO=1 samples in WAIT_START before giving up.
- LEN_W, $clog2(MAX_BITS+1), width of RESP_LEN.

Ports:
- CLK  input  1  SD clock domain; all sampling and state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- DO  input  1  card data out (MISO).
- ACTIVATE  input  1  request to receive a response; sampled in IDLE only.
- RESP_LEN  input  LEN_W  response length in bits; latched on acceptance.
- BUSY  output  1  high while in WAIT_START or SHIFT.
- RECEIVED  output  1  one-cycle pulse: response complete.
- TIMEOUT  output  1  one-cycle pulse: no start bit within TIMEOUT_CYCLES.
- RESPONSE  output  MAX_BITS  captured bits, right-aligned, first-received bit is MSB of the used field; upper unused bits 0.
- R1_ERROR  output  1  see Optional Feature.

Behaviour:
- Reset (synchronous, RESET=1 at a rising edge): state IDLE; BUSY=0, RECEIVED=0, TIMEOUT=0, RESPONSE=0, R1_ERROR=0; all counters 0. Reset overrides every other input, including mid-WAIT_START or mid-SHIFT; the partial response is discarded.
- States:
  - IDLE
  - WAIT_START
  - SHIFT
  - DONE (RECEIVED pulse)
  - TOUT (TIMEOUT pulse)
- IDLE: when ACTIVATE=1:
  - latch the effective length: RESP_LEN<8 -> 8; RESP_LEN>MAX_BITS -> MAX_BITS; otherwise RESP_LEN.
  - clear RESPONSE, bit count and wait count; go WAIT_START.
- WAIT_START:
  - DO=0 sampled: this is the start bit (the R1 MSB); shift it in as bit 0; bit count=1; go SHIFT.
  - DO=1 sampled: wait count+1; when the wait count reaches TIMEOUT_CYCLES, go TOUT.
- SHIFT: each edge does RESPONSE <= {RESPONSE[MAX_BITS-2:0], DO} and bit count+1. When the bit count reaches the effective length, go DONE; no extra sample is taken.
- DONE: RECEIVED=1 for exactly one cycle; RESPONSE stable from this cycle until the next acceptance; next state IDLE.
- TOUT: TIMEOUT=1 for exactly one cycle; RESPONSE=0; next state IDLE.
- Latency: with the start bit sampled at edge N, the last bit is sampled at edge N+len-1 and RECEIVED is high in the cycle after edge N+len.
- ACTIVATE during WAIT_START/SHIFT/DONE/TOUT: ignored; it is not queued.
- ACTIVATE held high: a new reception is accepted on the first IDLE edge after DONE/TOUT, so back-to-back operation is legal.
- RECEIVED and TIMEOUT are never high together.
- BUSY is low in IDLE, DONE and TOUT.
- Counters saturate/stop on exit; no wrap-around is possible within a reception.

Optional Feature:
- Macro: SD_RESP_R1_ERR_EN.
- Defined: in DONE, R1_ERROR = OR of bits 6..0 of the first received byte, i.e. RESPONSE[len-2 : len-8] of the used field. It is valid in the RECEIVED cycle and held until the next acceptance; cleared on acceptance and on TOUT.
- Undefined: R1_ERROR is tied to 0 and no extra logic is built.

Test Plan:
1. RESP_LEN=8, DO=1 for 10 cycles, then 0x00 -> RECEIVED pulse 8 cycles after the start-bit edge (+1); RESPONSE=0x00; BUSY falls; TIMEOUT stays 0.
2. RESP_LEN=40, DO=1 for 3 cycles, then 0x01_000001AA MSB-first -> RESPONSE=40'h01000001AA; single RECEIVED pulse.
3. RESP_LEN=8, DO held 1 -> TIMEOUT pulse after exactly 80 WAIT_START samples; RESPONSE=0; no RECEIVED.
4. RESET=1 at bit 20 of a 40-bit reception -> next cycle IDLE, BUSY=0, RESPONSE=0; a new ACTIVATE then receives 0x00 correctly.
5. ACTIVATE pulsed mid-SHIFT, and RESP_LEN=3 and RESP_LEN=63 -> the mid-SHIFT pulse is ignored; lengths are clamped to 8 and 40.
6. With SD_RESP_R1_ERR_EN: R1=0x05 -> R1_ERROR=1 with RECEIVED; R1=0x00 or 0x01 -> R1_ERROR=0? No: 0x01 gives R1_ERROR=1 (idle bit counts), 0x00 gives 0. Without the macro: R1_ERROR=0 always.

Source files
------------

// File: rtl/sd_response_receiver_if.sv
// Bus between an SD controller (master) and the SPI-mode response receiver (slave).
// Carries the card DO line, the request/length, and the status/result outputs.
interface sd_response_receiver_if #(
  parameter int MAX_BITS = 40,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
);
  logic                DO;
  logic                ACTIVATE;
  logic [LEN_W-1:0]    RESP_LEN;
  logic                BUSY;
  logic                RECEIVED;
  logic                TIMEOUT;
  logic [MAX_BITS-1:0] RESPONSE;
  logic                R1_ERROR;

  modport master (
    output DO, ACTIVATE, RESP_LEN,
    input  BUSY, RECEIVED, TIMEOUT, RESPONSE, R1_ERROR
  );

  modport slave (
    input  DO, ACTIVATE, RESP_LEN,
    output BUSY, RECEIVED, TIMEOUT, RESPONSE, R1_ERROR
  );
endinterface

// File: rtl/sd_response_receiver.sv
// SPI-mode SD response receiver: waits for the start bit on DO, shifts in 8..MAX_BITS bits,
// then pulses RECEIVED or TIMEOUT. Define SD_RESP_R1_ERR_EN to build the R1 error flag.
module sd_response_receiver #(
  parameter int MAX_BITS       = 40,
  parameter int TIMEOUT_CYCLES = 80,
  parameter int LEN_W          = $clog2(MAX_BITS + 1)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  sd_response_receiver_if.slave  bus
);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WAIT_START, SHIFT, DONE, TOUT} state_t;

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    len_reg;
  logic [LEN_W-1:0]    eff_len;
  logic [LEN_W-1:0]    bit_cnt_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [MAX_BITS-1:0] response_reg;
  logic                busy, received, timeout;

  // Requested length is clamped into the supported 8..MAX_BITS window.
  always_comb begin
    eff_len = bus.RESP_LEN;
    if (bus.RESP_LEN < LEN_W'(8))
      eff_len = LEN_W'(8);
    else if (bus.RESP_LEN > LEN_W'(MAX_BITS))
      eff_len = LEN_W'(MAX_BITS);
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.ACTIVATE)
          state_next = WAIT_START;
      end
      WAIT_START: begin
        if (!bus.DO)
          state_next = SHIFT;
        else if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1))
          state_next = TOUT;
      end
      SHIFT: begin
        // The length check happens before sampling, so the exit edge takes no extra bit.
        if (bit_cnt_reg == len_reg)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      TOUT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    received = 1'b0;
    timeout  = 1'b0;
    case (state_reg)
      WAIT_START: busy     = 1'b1;
      SHIFT:      busy     = 1'b1;
      DONE:       received = 1'b1;
      TOUT:       timeout  = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      len_reg      <= '0;
      bit_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      response_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (state_next == WAIT_START) begin
            len_reg      <= eff_len;
            bit_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            response_reg <= '0;
          end
        end
        WAIT_START: begin
          if (state_next == SHIFT) begin
            response_reg <= {response_reg[MAX_BITS-2:0], bus.DO};
            bit_cnt_reg  <= LEN_W'(1);
          end else if (state_next == TOUT) begin
            wait_cnt_reg <= WAIT_W'(TIMEOUT_CYCLES);
            response_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
          end
        end
        SHIFT: begin
          if (state_next == SHIFT) begin
            response_reg <= {response_reg[MAX_BITS-2:0], bus.DO};
            bit_cnt_reg  <= bit_cnt_reg + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.BUSY     = busy;
  assign bus.RECEIVED = received;
  assign bus.TIMEOUT  = timeout;
  assign bus.RESPONSE = response_reg;

`ifdef SD_RESP_R1_ERR_EN
  // One candidate flag per possible length; the R1 byte sits at the top of the used field.
  logic [MAX_BITS:0] r1_err_by_len;
  logic              r1_error_reg;

  genvar gi;
  for (gi = 0; gi <= MAX_BITS; gi++) begin : g_r1
    if (gi >= 8) begin : g_len
      assign r1_err_by_len[gi] = |response_reg[gi-2 -: 7];
    end else begin : g_short
      assign r1_err_by_len[gi] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      r1_error_reg <= 1'b0;
    else if (state_reg == IDLE && state_next == WAIT_START)
      r1_error_reg <= 1'b0;
    else if (state_reg == SHIFT && state_next == DONE)
      r1_error_reg <= r1_err_by_len[len_reg];
    else if (state_next == TOUT)
      r1_error_reg <= 1'b0;
  end

  assign bus.R1_ERROR = r1_error_reg;
`else
  assign bus.R1_ERROR = 1'b0;
`endif

endmodule

// File: tb/tb_sd_response_receiver.sv
// Randomised and directed bench for sd_response_receiver against a stream-level model.
module tb_sd_response_receiver;
  localparam int MAX_BITS       = 40;
  localparam int TIMEOUT_CYCLES = 80;
  localparam int LEN_W          = $clog2(MAX_BITS + 1);

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  sd_response_receiver_if #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) bus ();

  sd_response_receiver #(
    .MAX_BITS      (MAX_BITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .LEN_W         (LEN_W)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour from the stream view: 'waits' ones, then a start-bit-led word of
  // the clamped length; a timeout if the first TIMEOUT_CYCLES samples are all ones.
  task automatic transact(input string name, input int len_in, input int waits,
                          input logic [63:0] data, input bit mid_pulse);
    int          eff, exp_idx, rec_idx, tout_idx, rec_cnt, tout_cnt, busy_err;
    bit          exp_tout;
    logic [63:0] exp_resp;
    logic        exp_r1;
    eff      = (len_in < 8) ? 8 : ((len_in > MAX_BITS) ? MAX_BITS : len_in);
    exp_tout = (waits >= TIMEOUT_CYCLES);
    exp_idx  = exp_tout ? TIMEOUT_CYCLES : waits + 1 + eff;
    exp_resp = exp_tout ? 64'd0 : data;
`ifdef SD_RESP_R1_ERR_EN
    exp_r1 = exp_tout ? 1'b0 : (((data >> (eff - 8)) & 64'h7f) != 64'd0);
`else
    exp_r1 = 1'b0;
`endif
    rec_idx = -1; tout_idx = -1; rec_cnt = 0; tout_cnt = 0; busy_err = 0;
    @(negedge clk);
    bus.ACTIVATE = 1'b1;
    bus.RESP_LEN = LEN_W'(len_in);
    bus.DO       = 1'b1;
    @(negedge clk);
    check({name, "_busy_accept"}, 64'(bus.BUSY), 64'd1);
    for (int k = 0; k < exp_idx + 2; k++) begin
      bus.ACTIVATE = (mid_pulse && k == waits + 3);
      if (k < waits)
        bus.DO = 1'b1;
      else if (k < waits + eff)
        bus.DO = data[eff - 1 - (k - waits)];
      else
        bus.DO = 1'b1;
      @(negedge clk);
      if (k + 1 < exp_idx && bus.BUSY !== 1'b1)
        busy_err++;
      if (bus.RECEIVED === 1'b1) begin
        rec_cnt++;
        if (rec_idx < 0) begin
          rec_idx = k + 1;
          check({name, "_response"}, 64'(bus.RESPONSE), exp_resp);
          check({name, "_r1_error"}, 64'(bus.R1_ERROR), 64'(exp_r1));
        end
      end
      if (bus.TIMEOUT === 1'b1) begin
        tout_cnt++;
        if (tout_idx < 0) begin
          tout_idx = k + 1;
          check({name, "_tout_response"}, 64'(bus.RESPONSE), 64'd0);
        end
      end
    end
    bus.ACTIVATE = 1'b0;
    check({name, "_busy_during"}, 64'(busy_err), 64'd0);
    check({name, "_rx_edge"}, 64'(rec_idx), exp_tout ? 64'(-1) : 64'(exp_idx));
    check({name, "_rx_pulses"}, 64'(rec_cnt), exp_tout ? 64'd0 : 64'd1);
    check({name, "_tout_edge"}, 64'(tout_idx), exp_tout ? 64'(exp_idx) : 64'(-1));
    check({name, "_tout_pulses"}, 64'(tout_cnt), exp_tout ? 64'd1 : 64'd0);
    check({name, "_busy_after"}, 64'(bus.BUSY), 64'd0);
    check({name, "_response_held"}, 64'(bus.RESPONSE), exp_resp);
    $display("txn %s: len_in=%0d eff=%0d waits=%0d rx_edge=%0d tout_edge=%0d resp=%0h r1=%0b",
             name, len_in, eff, waits, rec_idx, tout_idx, bus.RESPONSE, bus.R1_ERROR);
  endtask

  function automatic logic [63:0] rand_word(input int len_in);
    int          eff;
    logic [63:0] w;
    eff = (len_in < 8) ? 8 : ((len_in > MAX_BITS) ? MAX_BITS : len_in);
    w   = {$urandom, $urandom};
    w   = w & ((64'd1 << eff) - 64'd1);
    return w & ~(64'd1 << (eff - 1));
  endfunction

  initial begin
    int          len_r, waits_r;
    logic [63:0] w;
    n_checks = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1;
    bus.DO = 1'b1; bus.ACTIVATE = 1'b0; bus.RESP_LEN = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.BUSY), 64'd0);
    check("reset_received", 64'(bus.RECEIVED), 64'd0);
    check("reset_timeout", 64'(bus.TIMEOUT), 64'd0);
    check("reset_response", 64'(bus.RESPONSE), 64'd0);
    check("reset_r1", 64'(bus.R1_ERROR), 64'd0);
    rst = 1'b0;

    transact("r1_zero", 8, 10, 64'h00, 1'b0);
    transact("r7_word", 40, 3, 64'h01000001AA, 1'b0);
    transact("timeout", 8, 200, 64'h00, 1'b0);
    transact("last_wait", 8, TIMEOUT_CYCLES - 1, 64'h05, 1'b0);

    // Reset in the middle of a 40-bit reception.
    @(negedge clk);
    bus.ACTIVATE = 1'b1; bus.RESP_LEN = LEN_W'(40); bus.DO = 1'b1;
    @(negedge clk);
    bus.ACTIVATE = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.DO = (k == 0) ? 1'b0 : 1'(k % 2);
      @(negedge clk);
    end
    check("pre_reset_busy", 64'(bus.BUSY), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_busy", 64'(bus.BUSY), 64'd0);
    check("mid_reset_response", 64'(bus.RESPONSE), 64'd0);
    check("mid_reset_received", 64'(bus.RECEIVED), 64'd0);
    transact("after_reset", 8, 2, 64'h00, 1'b0);

    transact("mid_pulse", 40, 4, rand_word(40), 1'b1);
    transact("clamp_low", 3, 1, 64'h7F, 1'b0);
    transact("clamp_high", 63, 0, rand_word(63), 1'b0);
    transact("r1_05", 8, 2, 64'h05, 1'b0);
    transact("r1_01", 8, 2, 64'h01, 1'b0);
    transact("r1_00", 8, 2, 64'h00, 1'b0);

    for (int i = 0; i < 10; i++) begin
      len_r   = $urandom_range(0, 63);
      waits_r = $urandom_range(0, 30);
      w       = rand_word(len_r);
      transact("random", len_r, waits_r, w, ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
